// File: rtl/tick_scheduler.sv
// tick_scheduler: one programmable rate counter shared by NUM_REQ requesters.
// A round-robin arbiter hands the counter to one requester at a time. The
// block then emits that requester's burst of single-cycle ticks, followed by a
// one-cycle completion pulse. A requester with a burst length of 0 runs
// continuously until it drops its request.
//
// Optional feature: define TICK_SCHEDULER_TOGGLE_EN to build a square-wave
// output that toggles on every tick. Without it, out_o is tied low.
module tick_scheduler #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned COUNT_WIDTH = 32,
  parameter int unsigned TICKS_WIDTH = 8
) (
  input  logic                           clock_i,
  input  logic                           reset_i,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [NUM_REQ*COUNT_WIDTH-1:0] period_i,
  input  logic [NUM_REQ*TICKS_WIDTH-1:0] ticks_i,
  output logic [NUM_REQ-1:0]             grant_o,
  output logic                           tick_o,
  output logic [NUM_REQ-1:0]             done_o,
  output logic                           busy_o,
  output logic                           out_o
);

  localparam int unsigned PtrWidth = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_e;

  state_e                   state_q, state_d;
  logic [PtrWidth-1:0]      ptr_q, ptr_d;
  logic [COUNT_WIDTH-1:0]   per_q, per_d;
  logic [COUNT_WIDTH-1:0]   count_q, count_d;
  logic [TICKS_WIDTH-1:0]   rem_q, rem_d;
  logic [NUM_REQ-1:0]       grant_q, grant_d;
  logic [NUM_REQ-1:0]       done_q, done_d;

  logic                     arb_found;
  logic [PtrWidth-1:0]      arb_sel;
  logic                     tick;
  logic                     req_active;

  // Unpacked views of the flattened per-requester fields.
  logic [COUNT_WIDTH-1:0]   period_arr [NUM_REQ];
  logic [TICKS_WIDTH-1:0]   ticks_arr  [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign period_arr[k] = period_i[k*COUNT_WIDTH +: COUNT_WIDTH];
    assign ticks_arr[k]  = ticks_i[k*TICKS_WIDTH +: TICKS_WIDTH];
  end

  // Round-robin scan: first active request at or after ptr_q, wrapping around.
  always_comb begin : arbiter
    int unsigned         idx;
    logic [PtrWidth-1:0] cand;
    arb_found = 1'b0;
    arb_sel   = '0;
    idx       = 0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      cand = PtrWidth'(idx);
      if (!arb_found && req_i[cand]) begin
        arb_found = 1'b1;
        arb_sel   = cand;
      end
    end
  end

  // Tick is decoded purely from registered state so it never glitches on inputs.
  assign tick       = (state_q == StRun) && (count_q == per_q);
  assign req_active = |(req_i & grant_q);

  // Next-state logic: arbitration in idle, counting and burst bookkeeping in run.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    per_d   = per_q;
    count_d = count_q;
    rem_d   = rem_q;
    grant_d = grant_q;
    done_d  = '0;

    unique case (state_q)
      StIdle: begin
        if (arb_found) begin
          per_d   = period_arr[arb_sel];
          rem_d   = ticks_arr[arb_sel];
          count_d = '0;
          grant_d = NUM_REQ'(1) << arb_sel;
          if (arb_sel == PtrWidth'(NUM_REQ - 1)) begin
            ptr_d = '0;
          end else begin
            ptr_d = arb_sel + 1'b1;
          end
          state_d = StRun;
        end
      end

      StRun: begin
        if (tick) begin
          count_d = '0;
          // rem_q of zero means continuous: never decremented.
          if (rem_q != '0) begin
            rem_d = rem_q - 1'b1;
          end
        end else begin
          count_d = count_q + 1'b1;
        end

        // A withdrawn request wins over completion: an aborted burst never reports done.
        if (!req_active) begin
          state_d = StIdle;
          grant_d = '0;
        end else if (tick && (rem_q == TICKS_WIDTH'(1))) begin
          state_d = StIdle;
          grant_d = '0;
          done_d  = grant_q;
        end
      end

      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      per_q   <= '0;
      count_q <= '0;
      rem_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      per_q   <= per_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      grant_q <= grant_d;
      done_q  <= done_d;
    end
  end

`ifdef TICK_SCHEDULER_TOGGLE_EN
  logic out_q, out_d;

  // Square wave: cleared on each new grant, flipped per tick, held while idle.
  always_comb begin
    out_d = out_q;
    if ((state_q == StIdle) && arb_found) begin
      out_d = 1'b0;
    end else if (tick) begin
      out_d = ~out_q;
    end
  end

  // Toggle flop with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      out_q <= 1'b0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out_o = out_q;
`else
  assign out_o = 1'b0;
`endif

  assign grant_o = grant_q;
  assign done_o  = done_q;
  assign busy_o  = (state_q == StRun);
  assign tick_o  = tick;

  // Structural invariants of the grant/done outputs.
  a_busy_onehot : assert property (@(posedge clock_i) disable iff (reset_i)
    busy_o |-> $onehot(grant_o));
  a_idle_nogrant : assert property (@(posedge clock_i) disable iff (reset_i)
    !busy_o |-> (grant_o == '0));
  a_done_grant_excl : assert property (@(posedge clock_i) disable iff (reset_i)
    (grant_o & done_o) == '0);

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed testbench for tick_scheduler: a cycle-by-cycle vector table covering
// burst timing, round-robin order, zero period, continuous mode with abort and
// reset mid-burst, plus a hand-written toggle-output sequence.
module tb_tick_scheduler;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   req = '0;
  logic [127:0] period = '0;
  logic [31:0]  ticks = '0;
  logic [3:0]   grant;
  logic         tick;
  logic [3:0]   done;
  logic         busy;
  logic         out;

  tick_scheduler #(
    .NUM_REQ    (4),
    .COUNT_WIDTH(32),
    .TICKS_WIDTH(8)
  ) dut (
    .clock_i (clock),
    .reset_i (reset),
    .req_i   (req),
    .period_i(period),
    .ticks_i (ticks),
    .grant_o (grant),
    .tick_o  (tick),
    .done_o  (done),
    .busy_o  (busy),
    .out_o   (out)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] p;
    logic [7:0]  n;
    logic [3:0]  grant;
    logic        tick;
    logic [3:0]  done;
    logic        busy;
  } vec_t;

  vec_t vecs[$];
  int   passed = 0;
  int   total = 0;
  int   overlap_err = 0;
  int   out_err = 0;

  task automatic add(input string name, input logic rst, input logic [3:0] rq,
                     input logic [31:0] p, input logic [7:0] n, input logic [3:0] g,
                     input logic t, input logic [3:0] d, input logic b);
    vec_t v;
    v.name = name; v.rst = rst; v.req = rq; v.p = p; v.n = n;
    v.grant = g; v.tick = t; v.done = d; v.busy = b;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Continuous monitors, summarised once at the end.
  always @(negedge clock) begin
    if (!reset && ((grant & done) != 4'b0000)) overlap_err++;
`ifndef TICK_SCHEDULER_TOGGLE_EN
    if (out !== 1'b0) out_err++;
`endif
  end

  initial begin
    // Burst timing: P=3, N=2 on requester 0, straight out of reset.
    add("burst_c0", 0, 4'b0001, 3, 2, 4'b0000, 0, 4'b0000, 0);
    for (int c = 1; c <= 3; c++) add("burst_run", 0, 4'b0001, 3, 2, 4'b0001, 0, 4'b0000, 1);
    add("burst_tick1", 0, 4'b0001, 3, 2, 4'b0001, 1, 4'b0000, 1);
    for (int c = 5; c <= 7; c++) add("burst_run", 0, 4'b0001, 3, 2, 4'b0001, 0, 4'b0000, 1);
    add("burst_tick2", 0, 4'b0001, 3, 2, 4'b0001, 1, 4'b0000, 1);
    add("burst_done", 0, 4'b0000, 3, 2, 4'b0000, 0, 4'b0001, 0);
    add("burst_idle", 0, 4'b0000, 3, 2, 4'b0000, 0, 4'b0000, 0);

    // Round-robin between requesters 0 and 2 (P=1, N=1), pointer reset first.
    add("rr_reset", 1, 4'b0000, 1, 1, 4'b0000, 0, 4'b0000, 0);
    add("rr_c0", 0, 4'b0101, 1, 1, 4'b0000, 0, 4'b0000, 0);
    for (int k = 0; k < 4; k++) begin
      logic [3:0] g;
      g = (k % 2 == 0) ? 4'b0001 : 4'b0100;
      add("rr_grant", 0, 4'b0101, 1, 1, g, 0, 4'b0000, 1);
      add("rr_tick", 0, 4'b0101, 1, 1, g, 1, 4'b0000, 1);
      add("rr_done", 0, (k == 3) ? 4'b0000 : 4'b0101, 1, 1, 4'b0000, 0, g, 0);
    end
    add("rr_idle", 0, 4'b0000, 1, 1, 4'b0000, 0, 4'b0000, 0);

    // Zero period: P=0, N=3 on requester 1.
    add("zp_c0", 0, 4'b0010, 0, 3, 4'b0000, 0, 4'b0000, 0);
    for (int c = 1; c <= 3; c++) add("zp_tick", 0, 4'b0010, 0, 3, 4'b0010, 1, 4'b0000, 1);
    add("zp_done", 0, 4'b0000, 0, 3, 4'b0000, 0, 4'b0010, 0);
    add("zp_idle", 0, 4'b0000, 0, 3, 4'b0000, 0, 4'b0000, 0);

    // Continuous mode (P=2, N=0) on requester 0, abort at cycle 10, requester 3 pending.
    add("cont_reset", 1, 4'b0000, 2, 0, 4'b0000, 0, 4'b0000, 0);
    add("cont_c0", 0, 4'b1001, 2, 0, 4'b0000, 0, 4'b0000, 0);
    for (int c = 1; c <= 9; c++)
      add("cont_run", 0, 4'b1001, 2, 0, 4'b0001, (c % 3 == 0), 4'b0000, 1);
    add("cont_abort", 0, 4'b1000, 2, 0, 4'b0001, 0, 4'b0000, 1);
    add("cont_idle", 0, 4'b1000, 2, 0, 4'b0000, 0, 4'b0000, 0);
    add("cont_g3", 0, 4'b1000, 2, 0, 4'b1000, 0, 4'b0000, 1);
    add("cont_g3", 0, 4'b1000, 2, 0, 4'b1000, 0, 4'b0000, 1);
    add("cont_g3_tick", 0, 4'b1000, 2, 0, 4'b1000, 1, 4'b0000, 1);
    add("cont_g3_abort", 0, 4'b0000, 2, 0, 4'b1000, 0, 4'b0000, 1);
    add("cont_end", 0, 4'b0000, 2, 0, 4'b0000, 0, 4'b0000, 0);

    // Reset at cycle 5 of a P=7 burst on requester 0; the grant moved ptr to 1.
    add("rst_c0", 0, 4'b0001, 7, 1, 4'b0000, 0, 4'b0000, 0);
    for (int c = 1; c <= 4; c++) add("rst_run", 0, 4'b0001, 7, 1, 4'b0001, 0, 4'b0000, 1);
    add("rst_assert", 1, 4'b0001, 7, 1, 4'b0001, 0, 4'b0000, 1);
    add("rst_cleared", 0, 4'b0011, 7, 1, 4'b0000, 0, 4'b0000, 0);
    add("rst_lowest", 0, 4'b0011, 7, 1, 4'b0001, 0, 4'b0000, 1);
    add("rst_abort", 0, 4'b0000, 7, 1, 4'b0001, 0, 4'b0000, 1);
    add("rst_idle", 0, 4'b0000, 7, 1, 4'b0000, 0, 4'b0000, 0);

    // Reset state.
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_grant", 32'(grant), 32'h0);
    check("reset_tick", 32'(tick), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_out", 32'(out), 32'h0);

    // Table: row i drives cycle i and checks the outputs during that cycle.
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clock);
      #1;
      reset  = vecs[i].rst;
      req    = vecs[i].req;
      period = {4{vecs[i].p}};
      ticks  = {4{vecs[i].n}};
      @(negedge clock);
      check($sformatf("%s[%0d] {grant,tick,done,busy}", vecs[i].name, i),
            32'({grant, tick, done, busy}),
            32'({vecs[i].grant, vecs[i].tick, vecs[i].done, vecs[i].busy}));
    end

    // Toggle output: P=1, N=4 on requester 0; ticks at cycles 2,4,6,8, done at 9.
    for (int c = 0; c <= 10; c++) begin
      logic [3:0] g_exp;
      logic       t_exp;
      logic [3:0] d_exp;
      logic       o_exp;
      @(posedge clock);
      #1;
      reset  = 1'b0;
      req    = (c <= 8) ? 4'b0001 : 4'b0000;
      period = {4{32'd1}};
      ticks  = {4{8'd4}};
      g_exp = (c >= 1 && c <= 8) ? 4'b0001 : 4'b0000;
      t_exp = (c == 2 || c == 4 || c == 6 || c == 8);
      d_exp = (c == 9) ? 4'b0001 : 4'b0000;
`ifdef TICK_SCHEDULER_TOGGLE_EN
      o_exp = (c == 3 || c == 4 || c == 7 || c == 8);
`else
      o_exp = 1'b0;
`endif
      @(negedge clock);
      check($sformatf("toggle_c%0d {grant,tick,done,busy}", c),
            32'({grant, tick, done, busy}), 32'({g_exp, t_exp, d_exp, (g_exp != 4'b0000)}));
      check($sformatf("toggle_c%0d out", c), 32'(out), 32'(o_exp));
    end

    check("grant_done_overlap_cycles", overlap_err, 0);
`ifndef TICK_SCHEDULER_TOGGLE_EN
    check("out_nonzero_cycles", out_err, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
